// File: rtl/lbp_engine.sv
// lbp_engine -- local-binary-pattern engine for the gray-image pipeline.
//
// Reads a (1<<ROW_BITS) x (1<<COL_BITS) image of DATA_W-bit unsigned pixels
// from the gray-image memory. Writes one 8-bit LBP code per pixel, in raster
// order, to the LBP result memory. Raises finish once the frame is done.
//
// Ports:
//   clk         rising-edge clock
//   reset       synchronous, active-high
//   gray_ready  source image available (sampled in IDLE only)
//   gray_req    read request qualifying gray_addr
//   gray_addr   read address {row,col}
//   gray_data   read data, valid the cycle after gray_req
//   lbp_valid   write strobe, one cycle per pixel
//   lbp_addr    write address {row,col}
//   lbp_data    LBP code, bits b7..b0 = w8,w7,w6,w5,w3,w2,w1,w0
//   finish      frame complete, held until reset
//
// Compile-time option LBP_EDGE_REPLICATE_EN: border pixels are computed with
// clamped (replicated) neighbour coordinates. Without it, border pixels take
// one cycle and get code 0.
module lbp_engine #(
  parameter int unsigned COL_BITS = 7,
  parameter int unsigned ROW_BITS = 7,
  parameter int unsigned DATA_W   = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         gray_ready,
  output logic                         gray_req,
  output logic [ROW_BITS+COL_BITS-1:0] gray_addr,
  input  logic [DATA_W-1:0]            gray_data,
  output logic                         lbp_valid,
  output logic [ROW_BITS+COL_BITS-1:0] lbp_addr,
  output logic [7:0]                   lbp_data,
  output logic                         finish
);
  localparam int unsigned AW = ROW_BITS + COL_BITS;
  localparam logic [ROW_BITS-1:0] ROW_MAX = '1;
  localparam logic [COL_BITS-1:0] COL_MAX = '1;
`ifdef LBP_EDGE_REPLICATE_EN
  localparam logic [COL_BITS-1:0] FIRST_COL = '0;
`else
  localparam logic [COL_BITS-1:0] FIRST_COL = COL_BITS'(1);
`endif

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WRITE, S_EDGE, S_DONE} state_t;

  state_t              state_q;
  logic [ROW_BITS-1:0] row_q;
  logic [COL_BITS-1:0] col_q;
  logic [3:0]          k_q;
  logic                full_q;
  logic [DATA_W-1:0]   win_q [9];

  logic                gray_req_q, lbp_valid_q, finish_q;
  logic [AW-1:0]       gray_addr_q, lbp_addr_q;
  logic [7:0]          lbp_data_q;

  logic [DATA_W-1:0]   win_d [9];
  logic [7:0]          code_d;
  logic [3:0]          n_cnt, k_nx;
  logic [ROW_BITS-1:0] nr;
  logic [COL_BITS-1:0] nc;
  logic                last, n_full, start;
`ifndef LBP_EDGE_REPLICATE_EN
  logic                n_border;
`endif

  // Window slot filled by read k: full fetch is centre first, then the
  // neighbours in raster order; a partial fetch fills the right column.
  function automatic logic [3:0] slot_of(input logic [3:0] k, input logic full);
    logic [3:0] s;
    if (full) begin
      case (k)
        4'd0:    s = 4'd4;
        4'd1:    s = 4'd0;
        4'd2:    s = 4'd1;
        4'd3:    s = 4'd2;
        4'd4:    s = 4'd3;
        4'd5:    s = 4'd5;
        4'd6:    s = 4'd6;
        4'd7:    s = 4'd7;
        default: s = 4'd8;
      endcase
    end else begin
      case (k)
        4'd0:    s = 4'd2;
        4'd1:    s = 4'd5;
        default: s = 4'd8;
      endcase
    end
    return s;
  endfunction

  // Neighbour address for a window slot; coordinates clamp at the image
  // edges, which only matters when border pixels are actually fetched.
  function automatic logic [AW-1:0] addr_of(input logic [ROW_BITS-1:0] r,
                                            input logic [COL_BITS-1:0] c,
                                            input logic [3:0]          slot);
    logic [ROW_BITS-1:0] rr;
    logic [COL_BITS-1:0] cc;
    rr = r;
    cc = c;
    if (slot < 4'd3) begin
      if (r != '0) rr = r - 1'b1;
    end else if (slot > 4'd5) begin
      if (r != ROW_MAX) rr = r + 1'b1;
    end
    case (slot)
      4'd0, 4'd3, 4'd6: if (c != '0) cc = c - 1'b1;
      4'd2, 4'd5, 4'd8: if (c != COL_MAX) cc = c + 1'b1;
      default: ;
    endcase
    return {rr, cc};
  endfunction

  assign n_cnt = full_q ? 4'd9 : 4'd3;
  assign k_nx  = k_q + 4'd1;

  // Window including the sample arriving this cycle, so the code can be
  // registered on the same edge that captures the last read.
  always_comb begin
    win_d = win_q;
    if (k_q != 4'd0) win_d[slot_of(k_q - 4'd1, full_q)] = gray_data;
    code_d[0] = win_d[0] >= win_d[4];
    code_d[1] = win_d[1] >= win_d[4];
    code_d[2] = win_d[2] >= win_d[4];
    code_d[3] = win_d[3] >= win_d[4];
    code_d[4] = win_d[5] >= win_d[4];
    code_d[5] = win_d[6] >= win_d[4];
    code_d[6] = win_d[7] >= win_d[4];
    code_d[7] = win_d[8] >= win_d[4];
  end

  always_comb begin
    if (state_q == S_IDLE) begin
      nr = '0;
      nc = '0;
    end else if (col_q == COL_MAX) begin
      nr = row_q + 1'b1;
      nc = '0;
    end else begin
      nr = row_q;
      nc = col_q + 1'b1;
    end
    last   = (row_q == ROW_MAX) && (col_q == COL_MAX);
    n_full = (nc == FIRST_COL);
`ifndef LBP_EDGE_REPLICATE_EN
    n_border = (nr == '0) || (nr == ROW_MAX) || (nc == '0) || (nc == COL_MAX);
`endif
    start = ((state_q == S_IDLE) && gray_ready) ||
            (((state_q == S_WRITE) || (state_q == S_EDGE)) && !last);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      row_q       <= '0;
      col_q       <= '0;
      k_q         <= '0;
      full_q      <= 1'b0;
      win_q       <= '{default: '0};
      gray_req_q  <= 1'b0;
      gray_addr_q <= '0;
      lbp_valid_q <= 1'b0;
      lbp_addr_q  <= '0;
      lbp_data_q  <= '0;
      finish_q    <= 1'b0;
    end else begin
      case (state_q)
        S_FETCH: begin
          win_q <= win_d;
          if (k_q == n_cnt) begin
            state_q     <= S_WRITE;
            lbp_valid_q <= 1'b1;
            lbp_addr_q  <= {row_q, col_q};
            lbp_data_q  <= code_d;
          end else begin
            k_q <= k_nx;
            if (k_nx < n_cnt) begin
              gray_req_q  <= 1'b1;
              gray_addr_q <= addr_of(row_q, col_q, slot_of(k_nx, full_q));
            end else begin
              gray_req_q <= 1'b0;
            end
          end
        end
        S_WRITE, S_EDGE: begin
          lbp_valid_q <= 1'b0;
          if (last) begin
            state_q  <= S_DONE;
            finish_q <= 1'b1;
          end
        end
        default: ;
      endcase

      // Entry into the next pixel, shared by IDLE and the per-pixel exits;
      // these assignments take precedence over the ones above.
      if (start) begin
        row_q <= nr;
        col_q <= nc;
        k_q   <= '0;
`ifndef LBP_EDGE_REPLICATE_EN
        if (n_border) begin
          state_q     <= S_EDGE;
          lbp_valid_q <= 1'b1;
          lbp_addr_q  <= {nr, nc};
          lbp_data_q  <= '0;
        end else
`endif
        begin
          state_q     <= S_FETCH;
          full_q      <= n_full;
          gray_req_q  <= 1'b1;
          gray_addr_q <= addr_of(nr, nc, n_full ? 4'd4 : 4'd2);
          lbp_valid_q <= 1'b0;
          if (!n_full) begin
            win_q[0] <= win_q[1];
            win_q[1] <= win_q[2];
            win_q[3] <= win_q[4];
            win_q[4] <= win_q[5];
            win_q[6] <= win_q[7];
            win_q[7] <= win_q[8];
          end
        end
      end
    end
  end

  assign gray_req  = gray_req_q;
  assign gray_addr = gray_addr_q;
  assign lbp_valid = lbp_valid_q;
  assign lbp_addr  = lbp_addr_q;
  assign lbp_data  = lbp_data_q;
  assign finish    = finish_q;

endmodule

// File: tb/tb_lbp_engine.sv
// Directed bench for lbp_engine on an 8x8 image with 12-bit pixels.
module tb_lbp_engine;
  localparam int unsigned CB = 3;
  localparam int unsigned RB = 3;
  localparam int unsigned DW = 12;
  localparam int NPIX = 64;
  localparam int MAXI = 7;
  localparam int LIMIT = 2000;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            gray_ready = 1'b0;
  logic            gray_req;
  logic [RB+CB-1:0] gray_addr;
  logic [DW-1:0]   gray_data = '0;
  logic            lbp_valid;
  logic [RB+CB-1:0] lbp_addr;
  logic [7:0]      lbp_data;
  logic            finish;

  always #5 clk = ~clk;

  lbp_engine #(
    .COL_BITS(CB),
    .ROW_BITS(RB),
    .DATA_W  (DW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .gray_ready(gray_ready),
    .gray_req  (gray_req),
    .gray_addr (gray_addr),
    .gray_data (gray_data),
    .lbp_valid (lbp_valid),
    .lbp_addr  (lbp_addr),
    .lbp_data  (lbp_data),
    .finish    (finish)
  );

  logic [DW-1:0] mem [NPIX];
  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Gray memory: one-cycle read latency.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (gray_req) gray_data <= mem[gray_addr];
  end

  // Write-side recorder.
  logic [31:0] wr_addr [1024];
  logic [31:0] wr_data [1024];
  logic [31:0] wr_time [1024];
  int   wr_n    = 0;
  int   clash   = 0;
  int   fin_cyc = -1;
  logic fin_prev = 1'b0;

  always @(negedge clk) begin
    if (lbp_valid && wr_n < 1024) begin
      wr_addr[wr_n] = 32'(lbp_addr);
      wr_data[wr_n] = 32'(lbp_data);
      wr_time[wr_n] = 32'(cyc);
      wr_n = wr_n + 1;
    end
    if (gray_req && lbp_valid) clash = clash + 1;
    if (finish && !fin_prev) fin_cyc = cyc;
    fin_prev = finish;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic bit is_border(input int r, input int c);
    return (r == 0) || (r == MAXI) || (c == 0) || (c == MAXI);
  endfunction

  // Reference LBP straight from image coordinates.
  function automatic int ref_code(input int r, input int c);
    int dr [8] = '{-1, -1, -1, 0, 0, 1, 1, 1};
    int dc [8] = '{-1, 0, 1, -1, 1, -1, 0, 1};
    int ctr;
    int nb;
    int v;
    v = 0;
    if (is_border(r, c)) return 0;
    ctr = int'(mem[r * 8 + c]);
    for (int b = 0; b < 8; b++) begin
      nb = int'(mem[(r + dr[b]) * 8 + c + dc[b]]);
      if (nb >= ctr) v = v | (1 << b);
    end
    return v;
  endfunction

  task automatic kick(output int base);
    @(negedge clk);
    base = wr_n;
    gray_ready = 1'b1;
    @(negedge clk);
    gray_ready = 1'b0;
  endtask

  // mode 0: constant image, 1: ramp, 2: reference model
  task automatic run_frame(input string name, input int mode, input bit timing, output int base);
    int n;
    int r;
    int c;
    int exp;
    kick(base);
    n = 0;
    while (finish !== 1'b1 && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check({name, "_finish"}, 32'(finish), 32'd1);
    check({name, "_nwr"}, 32'(wr_n - base), 32'd64);
    for (int i = 0; i < NPIX; i++) begin
      r = i / 8;
      c = i % 8;
      if (mode == 0)      exp = is_border(r, c) ? 0 : 'hFF;
      else if (mode == 1) exp = is_border(r, c) ? 0 : 'hD6;
      else                exp = ref_code(r, c);
      check($sformatf("%s_addr[%0d]", name, i), wr_addr[base + i], 32'(i));
      check($sformatf("%s_code[%0d]", name, i), wr_data[base + i], 32'(exp));
      if (timing && i > 0) begin
        exp = is_border(r, c) ? 1 : ((c == 1) ? 11 : 5);
        check($sformatf("%s_cycles[%0d]", name, i),
              wr_time[base + i] - wr_time[base + i - 1], 32'(exp));
      end
    end
    check({name, "_fin_lat"}, 32'(fin_cyc), wr_time[base + NPIX - 1] + 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rst_finish", 32'(finish), 32'd0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int base;
    int n;

    repeat (3) @(negedge clk);
    check("reset_gray_req",  32'(gray_req),  32'd0);
    check("reset_gray_addr", 32'(gray_addr), 32'd0);
    check("reset_lbp_valid", 32'(lbp_valid), 32'd0);
    check("reset_lbp_addr",  32'(lbp_addr),  32'd0);
    check("reset_lbp_data",  32'(lbp_data),  32'd0);
    check("reset_finish",    32'(finish),    32'd0);
    reset = 1'b0;

    for (int i = 0; i < NPIX; i++) mem[i] = 12'h037;
    run_frame("const", 0, 1'b1, base);
    do_reset();

    for (int i = 0; i < NPIX; i++) mem[i] = DW'(i % 8);
    run_frame("ramp", 1, 1'b0, base);
    do_reset();

    for (int i = 0; i < NPIX; i++) mem[i] = 12'd10;
    mem[5 * 8 + 5] = 12'd200;
    run_frame("imp", 2, 1'b0, base);
    check("imp_5_5", wr_data[base + 45], 32'h00);
    check("imp_4_4", wr_data[base + 36], 32'hFF);
    check("imp_6_6", wr_data[base + 54], 32'hFF);
    do_reset();

    for (int i = 0; i < NPIX; i++) mem[i] = DW'($urandom_range(0, 4095));
    run_frame("rand", 2, 1'b1, base);
    do_reset();

    // Reset in the middle of fetching pixel (4,3), then a full rerun on an
    // image with many ties.
    for (int i = 0; i < NPIX; i++) mem[i] = DW'($urandom_range(0, 3));
    kick(base);
    n = 0;
    while (!(gray_req === 1'b1 && wr_n - base == 35) && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    check("midrst_reach", 32'(n < LIMIT), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_gray_req",  32'(gray_req),  32'd0);
    check("midrst_lbp_valid", 32'(lbp_valid), 32'd0);
    check("midrst_finish",    32'(finish),    32'd0);
    check("midrst_gray_addr", 32'(gray_addr), 32'd0);
    check("midrst_lbp_data",  32'(lbp_data),  32'd0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst_idle_valid", 32'(lbp_valid), 32'd0);
    run_frame("rerun", 2, 1'b1, base);

    check("req_valid_overlap", 32'(clash), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
